apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

APB initiator that turns single register-access commands from a local requester into APB3 SETUP/ACCESS transfers toward the SPI controller's APB register file. It returns read data and error status over a valid/ready response channel. It sits between the host-side sequencer and the PCLK-domain APB bus. Only one transfer is outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 3, APB address width
- DATA_WIDTH, 8, APB data width
- TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles with PREADY_i low (used only when the timeout macro is defined); must be ≥1

Ports. Clock is PCLK; reset is PRESET_n, asynchronous, active-low.
- PCLK  in  1  APB clock
- PRESET_n  in  1  async active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  target register address
- cmd_wdata_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes, errors, and timeouts)
- rsp_err_o  out  1  PSLVERR_i sampled high, or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- busy_o  out  1  state ≠ IDLE
- PSEL_o, PENABLE_o, PWRITE_o  out  1 each  APB control
- PADDR_o  out  ADDR_WIDTH; PWDATA_o  out  DATA_WIDTH
- PRDATA_i  in  DATA_WIDTH; PREADY_i, PSLVERR_i  in  1 each

## Operation
FSM states are IDLE, SETUP, ACCESS and RESP. All outputs are registered except cmd_ready_o and busy_o, which decode the state.

- **Reset:** state = IDLE. All APB outputs, rsp_* outputs and the wait counter are 0.
- **IDLE:**
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch cmd_write_i into PWRITE_o and cmd_addr_i into PADDR_o.
  - On the same accept: latch PWDATA_o = cmd_wdata_i for writes, PWDATA_o = 0 for reads.
  - Set PSEL_o = 1 and go to SETUP.
- **SETUP:** PSEL_o = 1, PENABLE_o = 0. Unconditionally set PENABLE_o = 1 and go to ACCESS.
- **ACCESS:**
  - Hold PSEL_o = PENABLE_o = 1. PADDR_o, PWRITE_o and PWDATA_o stay stable.
  - When PREADY_i = 1:
    - capture rsp_rdata_o = PRDATA_i if read and PSLVERR_i = 0, else 0;
    - set rsp_err_o = PSLVERR_i;
    - clear PSEL_o and PENABLE_o;
    - set rsp_valid_o = 1 and go to RESP.
  - PRDATA_i and PSLVERR_i are ignored while PREADY_i = 0.
- **RESP:**
  - rsp_valid_o and the rsp fields stay stable until rsp_ready_i = 1.
  - On rsp_ready_i = 1: clear rsp_valid_o, rsp_err_o and rsp_timeout_o, then go to IDLE.
  - rsp_rdata_o keeps its value.
- **Command hold rules:**
  - cmd_valid_i outside IDLE is not accepted. The requester holds it.
  - A new command needs the previous response consumed plus one IDLE cycle.
- **Bus values in IDLE:** PADDR_o, PWRITE_o and PWDATA_o keep their last values. PSEL_o = 0.
- **Reset mid-transfer:** asynchronous return to the reset state. The pending response is discarded and PSEL_o drops immediately.

## Timing
- Command accepted at edge N:
  - SETUP is visible in cycle N+1.
  - ACCESS is visible in cycle N+2.
- PREADY_i = 1 in the first ACCESS cycle gives rsp_valid_o = 1 in cycle N+3. That is the minimum latency: 3 cycles.
- Each ACCESS cycle with PREADY_i = 0 adds 1 cycle.
- The codebase SPI register slave raises PREADY one cycle after PENABLE, so nominal latency against it is 4 cycles.
- PSEL_o and PENABLE_o fall in the cycle after PREADY_i is sampled high. There are no back-to-back transfers.
- Throughput is at most one transfer per 4 cycles with rsp_ready_i tied high.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- **Defined:**
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY_i = 0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: PSEL_o and PENABLE_o clear, and state goes to RESP.
  - Abort response: rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0.
  - If PREADY_i = 1 in the cycle the counter reaches the limit, PREADY_i wins and the transfer completes normally.
- **Undefined:**
  - No counter. ACCESS waits indefinitely.
  - rsp_timeout_o is tied 0 and TIMEOUT_CYCLES is unused.

## Test plan
- **Write, zero-wait:** write addr=3'b001, data=8'h1B; PREADY_i=1 in ACCESS -> PSEL high 2 cycles, PENABLE 1 cycle, PWDATA_o=8'h1B; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- **Read, one wait state:** read addr=3'b010; PREADY_i low 1 cycle, then high with PRDATA_i=8'h77 -> rsp_valid at N+4, rsp_rdata=8'h77; PADDR_o stable throughout ACCESS.
- **Slave error:** write addr=3'b101 with PSLVERR_i=1 and PREADY_i=1 -> rsp_err=1, rsp_timeout=0; PRDATA_i=8'hFF is ignored and rsp_rdata=0.
- **Response backpressure:** hold rsp_ready_i=0 for 5 cycles with cmd_valid_i held high -> rsp fields stable, cmd_ready_o=0; the next command is accepted one cycle after rsp_ready_i.
- **Timeout (macro defined, TIMEOUT_CYCLES=4):** hold PREADY_i=0 -> abort after 4 wait cycles with rsp_err=1, rsp_timeout=1. Repeat with PREADY_i=1 on the 4th cycle -> normal completion.
- **Reset mid-ACCESS:** assert PRESET_n low -> PSEL_o and PENABLE_o go to 0 asynchronously, rsp_valid_o=0, busy_o=0, cmd_ready_o=1 after release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// APB3 initiator. It accepts one register-access command at a time from a
// local requester and runs it on the APB bus as a SETUP/ACCESS transfer. It
// then returns read data and error status on a valid/ready response channel.
// Only one transfer is outstanding at a time.
//
// Optional feature (macro APB_MASTER_TIMEOUT_EN):
//   Enables an ACCESS wait counter. When the slave holds PREADY_i low for
//   TIMEOUT_CYCLES cycles, the transfer aborts with rsp_err_o = 1 and
//   rsp_timeout_o = 1. Without the macro, ACCESS waits forever and
//   rsp_timeout_o is tied 0.
//
// Ports:
//   PCLK, PRESET_n         clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    command handshake (ready only in IDLE)
//   cmd_write_i            1 = write, 0 = read
//   cmd_addr_i/wdata_i     target address / write data
//   rsp_valid_o/ready_i    response handshake
//   rsp_rdata_o            read data (0 for writes, errors, timeouts)
//   rsp_err_o              PSLVERR_i seen, or timeout
//   rsp_timeout_o          transfer aborted by timeout
//   busy_o                 FSM not in IDLE
//   PSEL_o .. PWDATA_o     APB requester outputs (registered)
//   PRDATA_i, PREADY_i,
//   PSLVERR_i              APB completer inputs
// ---------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 3,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET_n,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   output logic                  busy_o,
   output logic                  PSEL_o,
   output logic                  PENABLE_o,
   output logic                  PWRITE_o,
   output logic [ADDR_WIDTH-1:0] PADDR_o,
   output logic [DATA_WIDTH-1:0] PWDATA_o,
   input  logic [DATA_WIDTH-1:0] PRDATA_i,
   input  logic                  PREADY_i,
   input  logic                  PSLVERR_i
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int             CW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  TO_LIM = CW'(TIMEOUT_CYCLES);
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          rsp_timeout_q, rsp_timeout_d;
`else
   // The limit only matters when the timeout is built in.
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_d    = wait_cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               pwrite_d = cmd_write_i;
               paddr_d  = cmd_addr_i;
               pwdata_d = cmd_write_i ? cmd_wdata_i : '0;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         ACCESS: begin
            // PREADY_i takes priority over a timeout that would expire in the same cycle.
            if (PREADY_i) begin
               rsp_rdata_d = (!pwrite_q && !PSLVERR_i) ? PRDATA_i : '0;
               rsp_err_d   = PSLVERR_i;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
               if (wait_cnt_d == TO_LIM) begin
                  rsp_rdata_d   = '0;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  rsp_valid_d   = 1'b1;
                  state_d       = RESP;
               end
            end
`endif
         end
         RESP: begin
            // rsp_rdata_o intentionally keeps its value after the handshake.
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         wait_cnt_q    <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign PSEL_o      = psel_q;
   assign PENABLE_o   = penable_q;
   assign PWRITE_o    = pwrite_q;
   assign PADDR_o     = paddr_q;
   assign PWDATA_o    = pwdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
   assign rsp_timeout_o = rsp_timeout_q;
`else
   assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed bench for apb_master_bridge. Each response the slave is told to
// produce pushes its expected result onto a scoreboard queue. The entry is
// popped and compared when rsp_valid_o rises. Cycle-exact checks cover
// SETUP/ACCESS/RESP timing, backpressure, reset mid-transfer and, when the
// macro is defined, the ACCESS timeout.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int AW = 3;
   localparam int DW = 8;

   logic          PCLK = 1'b0;
   logic          PRESET_n;
   logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [AW-1:0] cmd_addr_i;
   logic [DW-1:0] cmd_wdata_i;
   logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o, busy_o;
   logic [DW-1:0] rsp_rdata_o;
   logic          PSEL_o, PENABLE_o, PWRITE_o;
   logic [AW-1:0] PADDR_o;
   logic [DW-1:0] PWDATA_o, PRDATA_i;
   logic          PREADY_i, PSLVERR_i;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      logic          to;
   } rsp_t;
   rsp_t sb[$];

   int n_assert = 0;
   int n_fail   = 0;

   apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
      .PCLK(PCLK), .PRESET_n(PRESET_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
      .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o),
      .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
      .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge PCLK);
      #1;
   endtask

   // Present a command in IDLE and check the SETUP and first ACCESS cycles.
   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_wdata_i = d;
      chk("cmd_ready_idle", cmd_ready_o, 1);
      tick;
      cmd_valid_i = 1'b0;
      chk("setup_psel", PSEL_o, 1);
      chk("setup_penable", PENABLE_o, 0);
      chk("setup_pwrite", PWRITE_o, w);
      chk("setup_paddr", PADDR_o, a);
      chk("setup_pwdata", PWDATA_o, w ? d : 8'h00);
      chk("setup_cmd_ready", cmd_ready_o, 0);
      chk("setup_busy", busy_o, 1);
      tick;
      chk("access_psel", PSEL_o, 1);
      chk("access_penable", PENABLE_o, 1);
      chk("access_rsp_valid", rsp_valid_o, 0);
   endtask

   task automatic check_rsp;
      rsp_t e;
      if (sb.size() == 0) begin
         chk("sb_underflow", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("rsp_rdata", rsp_rdata_o, e.rdata);
         chk("rsp_err", rsp_err_o, e.err);
         chk("rsp_timeout", rsp_timeout_o, e.to);
      end
   endtask

   // Insert 'waits' not-ready ACCESS cycles (with junk on PRDATA/PSLVERR), then complete.
   task automatic complete(input int waits, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] rd, input logic err);
      rsp_t e;
      e.rdata = (!w && !err) ? rd : 8'h00;
      e.err   = err;
      e.to    = 1'b0;
      sb.push_back(e);
      for (int i = 0; i < waits; i++) begin
         PREADY_i = 1'b0; PRDATA_i = 8'hEE; PSLVERR_i = 1'b1;
         tick;
         chk("wait_psel", PSEL_o, 1);
         chk("wait_penable", PENABLE_o, 1);
         chk("wait_paddr", PADDR_o, a);
         chk("wait_rsp_valid", rsp_valid_o, 0);
      end
      PREADY_i = 1'b1; PRDATA_i = rd; PSLVERR_i = err;
      tick;
      PREADY_i = 1'b0; PSLVERR_i = 1'b0; PRDATA_i = 8'h00;
      chk("done_rsp_valid", rsp_valid_o, 1);
      chk("done_psel", PSEL_o, 0);
      chk("done_penable", PENABLE_o, 0);
      check_rsp();
   endtask

   task automatic consume;
      rsp_ready_i = 1'b1;
      tick;
      rsp_ready_i = 1'b0;
      chk("consumed_rsp_valid", rsp_valid_o, 0);
      chk("consumed_rsp_err", rsp_err_o, 0);
      chk("consumed_rsp_timeout", rsp_timeout_o, 0);
      chk("consumed_busy", busy_o, 0);
   endtask

   initial begin
      PRESET_n = 1'b0;
      cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
      rsp_ready_i = 1'b0; PRDATA_i = '0; PREADY_i = 1'b0; PSLVERR_i = 1'b0;
      #12;
      chk("rst_psel", PSEL_o, 0);
      chk("rst_penable", PENABLE_o, 0);
      chk("rst_pwrite", PWRITE_o, 0);
      chk("rst_paddr", PADDR_o, 0);
      chk("rst_pwdata", PWDATA_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_rdata", rsp_rdata_o, 0);
      chk("rst_rsp_err", rsp_err_o, 0);
      chk("rst_rsp_timeout", rsp_timeout_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_cmd_ready", cmd_ready_o, 1);
      @(negedge PCLK);
      PRESET_n = 1'b1;
      tick;

      // Write, zero wait states: response 3 cycles after the accept.
      issue(1'b1, 3'b001, 8'h1B);
      complete(0, 1'b1, 3'b001, 8'hC3, 1'b0);
      consume();
      chk("idle_pwdata_hold", PWDATA_o, 8'h1B);
      chk("idle_paddr_hold", PADDR_o, 3'b001);

      // Read with one wait state.
      issue(1'b0, 3'b010, 8'h99);
      complete(1, 1'b0, 3'b010, 8'h77, 1'b0);
      consume();
      chk("idle_rdata_kept", rsp_rdata_o, 8'h77);

      // Slave error on a write: PRDATA is ignored.
      issue(1'b1, 3'b101, 8'h3C);
      complete(0, 1'b1, 3'b101, 8'hFF, 1'b1);
      consume();

      // Read that returns a slave error: read data is forced to zero.
      issue(1'b0, 3'b110, 8'h00);
      complete(2, 1'b0, 3'b110, 8'hA5, 1'b1);
      consume();

      // Response backpressure while the next command is already held.
      issue(1'b0, 3'b011, 8'h00);
      complete(0, 1'b0, 3'b011, 8'h42, 1'b0);
      cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 3'b111; cmd_wdata_i = 8'h5E;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("bp_rsp_valid", rsp_valid_o, 1);
         chk("bp_rsp_rdata", rsp_rdata_o, 8'h42);
         chk("bp_rsp_err", rsp_err_o, 0);
         chk("bp_cmd_ready", cmd_ready_o, 0);
         chk("bp_psel", PSEL_o, 0);
      end
      rsp_ready_i = 1'b1;
      tick;
      rsp_ready_i = 1'b0;
      chk("bp_released_valid", rsp_valid_o, 0);
      chk("bp_released_psel", PSEL_o, 0);
      issue(1'b1, 3'b111, 8'h5E);
      complete(0, 1'b1, 3'b111, 8'h00, 1'b0);
      consume();

`ifdef APB_MASTER_TIMEOUT_EN
      // PREADY never arrives: abort after 4 wait cycles.
      begin
         rsp_t e;
         issue(1'b0, 3'b100, 8'h00);
         e.rdata = 8'h00; e.err = 1'b1; e.to = 1'b1;
         sb.push_back(e);
         PREADY_i = 1'b0; PRDATA_i = 8'hEE;
         for (int i = 0; i < 3; i++) begin
            tick;
            chk("to_wait_psel", PSEL_o, 1);
            chk("to_wait_rsp_valid", rsp_valid_o, 0);
         end
         tick;
         chk("to_rsp_valid", rsp_valid_o, 1);
         chk("to_psel", PSEL_o, 0);
         chk("to_penable", PENABLE_o, 0);
         check_rsp();
         consume();
      end
      // PREADY on the 4th wait cycle beats the timeout.
      issue(1'b0, 3'b100, 8'h00);
      complete(3, 1'b0, 3'b100, 8'h5A, 1'b0);
      consume();
`else
      // Without the timeout, a long wait still completes normally.
      issue(1'b0, 3'b100, 8'h00);
      complete(6, 1'b0, 3'b100, 8'h5A, 1'b0);
      consume();
`endif

      // Reset asserted in the middle of ACCESS.
      issue(1'b1, 3'b011, 8'h81);
      PREADY_i = 1'b0;
      #2;
      PRESET_n = 1'b0;
      #1;
      chk("mid_rst_psel", PSEL_o, 0);
      chk("mid_rst_penable", PENABLE_o, 0);
      chk("mid_rst_rsp_valid", rsp_valid_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      @(negedge PCLK);
      PRESET_n = 1'b1;
      tick;
      chk("post_rst_cmd_ready", cmd_ready_o, 1);
      chk("post_rst_psel", PSEL_o, 0);

      // A transfer after the reset works normally.
      issue(1'b0, 3'b001, 8'h00);
      complete(0, 1'b0, 3'b001, 8'h3D, 1'b0);
      consume();

      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
